timer_disp_drv: RTL

TIMER_DISP_DRV -- requirements
Module: timer_disp_drv

---
 rtl/timer_disp_pkg.sv | 34 +++
 rtl/bcd_to_7seg.sv | 27 ++
 rtl/timer_disp_drv.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/timer_disp_pkg.sv
// Shared types and constants for the timer display driver.
package timer_disp_pkg;

  // Display mode as presented on the mode input.
  typedef enum logic [1:0] {
    ModeNormal  = 2'd0,
    ModeEditSec = 2'd1,
    ModeEditMin = 2'd2,
    ModeDone    = 2'd3
  } mode_e;

  // Update pipeline: one decode state per digit, then a single commit.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StDec0   = 3'd1,
    StDec1   = 3'd2,
    StDec2   = 3'd3,
    StDec3   = 3'd4,
    StCommit = 3'd5
  } state_e;

  // Active-low segment patterns {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // True when the mode blinks the given digit pair (hi = minutes pair).
  function automatic logic mode_blinks(input mode_e m, input logic hi);
    if (m == ModeDone) begin
      return 1'b1;
    end
    return hi ? (m == ModeEditMin) : (m == ModeEditSec);
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder; codes above 9 show a dash.
module bcd_to_7seg
  import timer_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Standard digit patterns, dash for non-decimal codes.
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/timer_disp_drv.sv
// Four-digit timer display driver: accepts a BCD update, decodes one digit per
// cycle through a shared decoder into shadow registers, commits all four digits
// at once, and blinks the digits under edit.
// Optional build macro TIMER_DISP_LZB_EN blanks HEX3 when the tens-of-minutes
// digit is zero.
module timer_disp_drv
  import timer_disp_pkg::*;
#(
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [15:0] digits,
  input  logic [1:0]  mode,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3
);

  localparam int unsigned CntW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(BLINK_DIV - 1);

  state_e          state_q, state_d;
  logic [15:0]     digits_q;
  mode_e           pend_mode_q;
  mode_e           mode_q;
  logic [6:0]      shadow_q [4];
  logic [6:0]      hex_q    [4];
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            phase_q, phase_d;
  logic            accept;
  logic            commit;
  logic            mode_change;
  logic [3:0]      dec_bcd;
  logic [6:0]      dec_seg;
  logic            blank_lo, blank_hi;

  // Handshake and update pipeline sequencing.
  always_comb begin
    state_d   = state_q;
    upd_ready = (state_q == StIdle);
    accept    = upd_valid && upd_ready;
    unique case (state_q)
      StIdle:   if (accept) state_d = StDec0;
      StDec0:   state_d = StDec1;
      StDec1:   state_d = StDec2;
      StDec2:   state_d = StDec3;
      StDec3:   state_d = StCommit;
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Select the digit for the shared decoder: DEC0 is onesSec, DEC3 is tensMin.
  always_comb begin
    dec_bcd = digits_q[3:0];
    case (state_q)
      StDec1:  dec_bcd = digits_q[7:4];
      StDec2:  dec_bcd = digits_q[11:8];
      StDec3:  dec_bcd = digits_q[15:12];
      default: dec_bcd = digits_q[3:0];
    endcase
  end

  bcd_to_7seg u_dec (
    .bcd (dec_bcd),
    .seg (dec_seg)
  );

  assign commit      = (state_q == StCommit);
  assign mode_change = commit && (pend_mode_q != mode_q);

  // Update capture, shadow fill and commit of visible digits and mode.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      digits_q    <= 16'h0000;
      pend_mode_q <= ModeNormal;
      mode_q      <= ModeNormal;
      for (int i = 0; i < 4; i++) begin
        shadow_q[i] <= SEG_BLANK;
        hex_q[i]    <= SEG_BLANK;
      end
    end else begin
      if (accept) begin
        digits_q    <= digits;
        pend_mode_q <= mode_e'(mode);
      end
      case (state_q)
        StDec0:  shadow_q[0] <= dec_seg;
        StDec1:  shadow_q[1] <= dec_seg;
        StDec2:  shadow_q[2] <= dec_seg;
        StDec3:  shadow_q[3] <= dec_seg;
        default: ;
      endcase
      if (commit) begin
        hex_q  <= shadow_q;
        mode_q <= pend_mode_q;
      end
    end
  end

  // Blink timebase; a mode change at commit restarts it visible, overriding a wrap.
  always_comb begin
    cnt_d   = cnt_q + CntW'(1);
    phase_d = phase_q;
    if (mode_change) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == CntMax) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  // Blink counter and phase registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign blank_lo = !phase_q && mode_blinks(mode_q, 1'b0);
  assign blank_hi = !phase_q && mode_blinks(mode_q, 1'b1);

`ifdef TIMER_DISP_LZB_EN
  logic [3:0] tens_q;

  // Committed tens-of-minutes value for leading-zero blanking.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tens_q <= 4'h0;
    end else if (commit) begin
      tens_q <= digits_q[15:12];
    end
  end

  // Output blanking over the stored patterns, tens zero always blank.
  always_comb begin
    HEX0 = blank_lo ? SEG_BLANK : hex_q[0];
    HEX1 = blank_lo ? SEG_BLANK : hex_q[1];
    HEX2 = blank_hi ? SEG_BLANK : hex_q[2];
    HEX3 = (blank_hi || (tens_q == 4'h0)) ? SEG_BLANK : hex_q[3];
  end
`else
  // Output blanking over the stored patterns.
  always_comb begin
    HEX0 = blank_lo ? SEG_BLANK : hex_q[0];
    HEX1 = blank_lo ? SEG_BLANK : hex_q[1];
    HEX2 = blank_hi ? SEG_BLANK : hex_q[2];
    HEX3 = blank_hi ? SEG_BLANK : hex_q[3];
  end
`endif

endmodule
